// File: rtl/rk4_deadlock_report_tx.sv
// Persistence-qualifies deadlock monitor block flags and streams one timestamped
// report {index, detection timestamp} per newly deadlocked monitor.
module rk4_deadlock_report_tx #(
    parameter int unsigned N_MON  = 4,
    parameter int unsigned THRESH = 16,
    parameter int unsigned TS_W   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_MON-1:0]     block_in,
    input  logic                 clear,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [8+TS_W-1:0]    rpt_data,
    output logic                 deadlock,
    output logic [7:0]           pending_cnt
);

    localparam int unsigned CNT_W = $clog2(THRESH + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [TS_W-1:0]    r_ts;
    logic [CNT_W-1:0]   r_persist [N_MON];
    logic [TS_W-1:0]    r_ts_cap  [N_MON];
    logic [N_MON-1:0]   r_pending;
    logic [N_MON-1:0]   r_reported;
    logic [N_MON-1:0]   r_sel_oh;
    logic               r_stale;
    logic               r_deadlock;
    logic [7:0]         r_pending_cnt;
    logic [8+TS_W-1:0]  r_data;

    logic [N_MON-1:0]   w_qual;
    logic [N_MON-1:0]   w_pending_nxt;
    logic [N_MON-1:0]   w_reported_nxt;
    logic [N_MON-1:0]   w_sel_oh;
    logic [7:0]         w_sel;
    logic [TS_W-1:0]    w_cap_sel;
    logic               w_found;
    logic [7:0]         w_popcnt;
    logic               w_hs;
    logic               w_load;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_nxt = SEND;
            SEND:    if (w_hs)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A clear on the load edge empties the pending mask, so no report is started.
    always_comb begin
        rpt_valid = (r_state == SEND);
        w_hs      = rpt_valid & rpt_ready;
        w_load    = (r_state == IDLE) & (|r_pending) & ~clear;
    end

    always_comb begin
        w_found   = 1'b0;
        w_sel     = '0;
        w_sel_oh  = '0;
        w_cap_sel = '0;
        for (int unsigned i = 0; i < N_MON; i++) begin
            if (r_pending[i] && !w_found) begin
                w_found     = 1'b1;
                w_sel       = 8'(i);
                w_sel_oh[i] = 1'b1;
                w_cap_sel   = r_ts_cap[i];
            end
        end
    end

    // A handshake of a report started before a clear (stale) must not touch the masks.
    always_comb begin
        w_qual         = '0;
        w_pending_nxt  = r_pending;
        w_reported_nxt = r_reported;
        w_popcnt       = '0;
        for (int unsigned i = 0; i < N_MON; i++) begin
            w_qual[i] = block_in[i] && (r_persist[i] == CNT_W'(THRESH - 1))
                        && !r_reported[i] && !r_pending[i];
        end
        if (clear) begin
            w_pending_nxt  = '0;
            w_reported_nxt = '0;
        end else begin
            if (w_hs && !r_stale) begin
                w_pending_nxt  = w_pending_nxt & ~r_sel_oh;
                w_reported_nxt = w_reported_nxt | r_sel_oh;
            end
            w_pending_nxt = w_pending_nxt | w_qual;
        end
        for (int unsigned i = 0; i < N_MON; i++) begin
            w_popcnt = w_popcnt + 8'(w_pending_nxt[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ts          <= '0;
            r_pending     <= '0;
            r_reported    <= '0;
            r_sel_oh      <= '0;
            r_stale       <= 1'b0;
            r_deadlock    <= 1'b0;
            r_pending_cnt <= '0;
            r_data        <= '0;
            for (int unsigned i = 0; i < N_MON; i++) begin
                r_persist[i] <= '0;
                r_ts_cap[i]  <= '0;
            end
        end else begin
            r_ts          <= r_ts + 1'b1;
            r_pending     <= w_pending_nxt;
            r_reported    <= w_reported_nxt;
            r_pending_cnt <= w_popcnt;
            for (int unsigned i = 0; i < N_MON; i++) begin
                if (clear || !block_in[i]) begin
                    r_persist[i] <= '0;
                end else if (r_persist[i] != CNT_W'(THRESH)) begin
                    r_persist[i] <= r_persist[i] + 1'b1;
                end
                if (w_qual[i] && !clear) begin
                    r_ts_cap[i] <= r_ts;
                end
            end
            if (clear) begin
                r_deadlock <= 1'b0;
            end else if (|w_qual) begin
                r_deadlock <= 1'b1;
            end
            if (w_load) begin
                r_data   <= {w_sel, w_cap_sel};
                r_sel_oh <= w_sel_oh;
                r_stale  <= 1'b0;
            end else if (clear) begin
                r_stale  <= 1'b1;
            end
        end
    end

    assign rpt_data    = r_data;
    assign deadlock    = r_deadlock;
    assign pending_cnt = r_pending_cnt;

endmodule

// File: tb/tb_rk4_deadlock_report_tx.sv
// Bench for rk4_deadlock_report_tx: run-length reference model checked every
// cycle, directed scenarios with literal expectations, and randomized traffic.
module tb_rk4_deadlock_report_tx;

    localparam int unsigned N  = 4;
    localparam int unsigned TH = 16;
    localparam int unsigned TW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    block_in = '0;
    logic            clear = 1'b0;
    logic            rpt_ready = 1'b1;
    logic            rpt_valid;
    logic [8+TW-1:0] rpt_data;
    logic            deadlock;
    logic [7:0]      pending_cnt;

    logic            wr_rst = 1'b0;
    logic [1:0]      wr_blk = '0;
    logic            wr_valid;
    logic [15:0]     wr_data;
    logic            wr_dl;
    logic [7:0]      wr_cnt;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    logic [15:0] wr_q[$];

    always #5 clk = ~clk;

    rk4_deadlock_report_tx #(.N_MON(N), .THRESH(TH), .TS_W(TW)) u_dut (
        .clock(clk), .reset(rst), .block_in(block_in), .clear(clear),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_data(rpt_data),
        .deadlock(deadlock), .pending_cnt(pending_cnt)
    );

    rk4_deadlock_report_tx #(.N_MON(2), .THRESH(4), .TS_W(8)) u_wrap (
        .clock(clk), .reset(wr_rst), .block_in(wr_blk), .clear(1'b0),
        .rpt_valid(wr_valid), .rpt_ready(1'b1), .rpt_data(wr_data),
        .deadlock(wr_dl), .pending_cnt(wr_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run lengths, pending/reported flags and one in-flight report.
    int unsigned m_run  [N];
    bit          m_pend [N];
    bit          m_rep  [N];
    logic [31:0] m_cap  [N];
    logic [31:0] m_ts;
    bit          m_valid;
    bit          m_stale;
    bit          m_dl;
    int          m_idx;
    logic [31:0] m_dts;

    always @(posedge clk or posedge rst) begin : model
        bit hs;
        bit load;
        int j;
        bit q [N];
        if (rst) begin
            m_ts = '0; m_valid = 0; m_stale = 0; m_dl = 0; m_idx = 0; m_dts = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_pend[i] = 0; m_rep[i] = 0; m_cap[i] = '0;
            end
        end else begin
            hs = m_valid && rpt_ready;
            j = -1;
            for (int i = 0; i < N; i++) if (m_pend[i] && j < 0) j = i;
            load = !m_valid && (j >= 0) && !clear;
            for (int i = 0; i < N; i++)
                q[i] = block_in[i] && (m_run[i] + 1 == TH) && !m_rep[i] && !m_pend[i];
            for (int i = 0; i < N; i++)
                m_run[i] = (block_in[i] && !clear) ? m_run[i] + 1 : 0;
            if (clear) begin
                for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_rep[i] = 0; end
                m_dl = 0;
                if (m_valid) m_stale = 1;
            end else begin
                if (hs && !m_stale) begin m_pend[m_idx] = 0; m_rep[m_idx] = 1; end
                for (int i = 0; i < N; i++)
                    if (q[i]) begin m_pend[i] = 1; m_cap[i] = m_ts; m_dl = 1; end
            end
            if (hs) m_valid = 0;
            if (load) begin m_valid = 1; m_idx = j; m_dts = m_cap[j]; m_stale = 0; end
            m_ts = m_ts + 1;
        end
    end

    function automatic logic [7:0] m_popcnt();
        logic [7:0] c = '0;
        for (int i = 0; i < N; i++) c = c + 8'(m_pend[i]);
        return c;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", rpt_valid, m_valid);
            chk("deadlock", deadlock, m_dl);
            chk("pending_cnt", pending_cnt, m_popcnt());
            if (m_valid) chk("data", rpt_data, {8'(m_idx), m_dts});
            if (rpt_valid && rpt_ready) hs_cnt++;
        end
        if (!wr_rst && wr_valid) wr_q.push_back(wr_data);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic wait_next_ts(input logic [31:0] t);
        int g = 0;
        while (m_ts != t && g < 2000) begin step(); g++; end
        chk("wait_ts_timeout", m_ts, t);
    endtask

    initial begin
        int hs0;
        logic [8+TW-1:0] d1;
        logic [31:0] c;

        #1 rst = 1'b1; wr_rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", rpt_valid, 0);
        chk("rst_data", rpt_data, 0);
        chk("rst_deadlock", deadlock, 0);
        chk("rst_pcnt", pending_cnt, 0);
        rst = 1'b0;

        // Single qualification at ts=100..115
        wait_next_ts(32'd100);
        hs0 = hs_cnt;
        block_in[2] = 1'b1;
        repeat (16) step();
        chk("t1_deadlock", deadlock, 1);
        chk("t1_not_yet", rpt_valid, 0);
        block_in[2] = 1'b0;
        step();
        chk("t1_valid", rpt_valid, 1);
        chk("t1_data", rpt_data, {8'd2, 32'd115});
        step();
        chk("t1_done", rpt_valid, 0);
        repeat (5) step();
        chk("t1_one_report", hs_cnt, hs0 + 1);

        // 15 high, 1 low, 15 high: never qualifies
        pulse_clear();
        chk("t2_cleared", deadlock, 0);
        hs0 = hs_cnt;
        block_in[0] = 1'b1; repeat (15) step();
        block_in[0] = 1'b0; step();
        block_in[0] = 1'b1; repeat (15) step();
        block_in[0] = 1'b0; repeat (4) step();
        chk("t2_no_deadlock", deadlock, 0);
        chk("t2_no_report", hs_cnt, hs0);

        // Simultaneous qualification of 1 and 3 under backpressure
        pulse_clear();
        rpt_ready = 1'b0;
        block_in = 4'b1010;
        repeat (16) step();
        block_in = '0;
        chk("t3_pcnt2", pending_cnt, 2);
        step();
        chk("t3_valid", rpt_valid, 1);
        chk("t3_idx1", rpt_data[39:32], 1);
        d1 = rpt_data;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_hold", rpt_data, d1);
        end
        rpt_ready = 1'b1;
        step();
        chk("t3_gap", rpt_valid, 0);
        chk("t3_pcnt1", pending_cnt, 1);
        step();
        chk("t3_idx3", rpt_data[39:32], 3);
        chk("t3_same_ts", rpt_data[31:0], d1[31:0]);
        step();
        chk("t3_pcnt0", pending_cnt, 0);

        // Held high after report: no second report; clear re-arms
        pulse_clear();
        hs0 = hs_cnt;
        block_in[2] = 1'b1;
        repeat (118) step();
        chk("t4_once", hs_cnt, hs0 + 1);
        c = m_ts;
        pulse_clear();
        chk("t5_cleared", deadlock, 0);
        repeat (15) step();
        chk("t5_not_yet", deadlock, 0);
        step();
        chk("t5_requal", deadlock, 1);
        step();
        chk("t5_data", rpt_data, {8'd2, c + 32'd16});
        step();
        block_in[2] = 1'b0;
        chk("t5_twice", hs_cnt, hs0 + 2);

        // Timestamp wrap on an 8-bit instance (THRESH=4)
        wr_rst = 1'b0;
        repeat (252) step();
        wr_blk = 2'b01; repeat (4) step();
        wr_blk = 2'b10; repeat (4) step();
        wr_blk = 2'b00; repeat (10) step();
        chk("wrap_count", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            chk("wrap_ff", wr_q[0], 16'h00FF);
            chk("wrap_03", wr_q[1], 16'h0103);
        end
        chk("wrap_dl", wr_dl, 1);

        // Reset while a report is stalled
        pulse_clear();
        rpt_ready = 1'b0;
        block_in[0] = 1'b1; repeat (16) step();
        block_in[0] = 1'b0; step();
        chk("t7_valid", rpt_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t7_async_valid", rpt_valid, 0);
        chk("t7_data", rpt_data, 0);
        chk("t7_dl", deadlock, 0);
        chk("t7_pcnt", pending_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        rpt_ready = 1'b1;
        hs0 = hs_cnt;
        repeat (30) step();
        chk("t7_no_replay", hs_cnt, hs0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < N; b++) begin
                if (block_in[b]) begin
                    if ($urandom_range(99) < 5) block_in[b] = 1'b0;
                end else if ($urandom_range(99) < 10) begin
                    block_in[b] = 1'b1;
                end
            end
            rpt_ready = ($urandom_range(99) < 70);
            clear = ($urandom_range(299) == 0);
            if (k == 1501) rst = 1'b0;
            if (k == 1500) #3 rst = 1'b1;
            step();
        end
        clear = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rk4_deadlock_report_tx.md
Name: rk4_deadlock_report_tx

Overview:
- Consumer end of the per-instance deadlock monitors: takes their `block` outputs and qualifies each by persistence.
- Sends one timestamped report per newly-deadlocked monitor over a valid/ready stream to the debug/AXI-Lite capture path.
- Sits beside the RK4_LBE_B_32 top; the monitors only flag, this block decides and reports.

Parameters:
- N_MON, 4, number of monitor `block` inputs (1..255).
- THRESH, 16, consecutive high cycles of a `block` input before it counts as a deadlock (>=1).
- TS_W, 32, width of the free-running timestamp.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- block_in  in  N_MON  `block` outputs of the deadlock monitors; bit i is monitor i.
- clear  in  1  synchronous one-cycle pulse; re-arms reporting.
- rpt_valid  out  1  report word valid.
- rpt_ready  in  1  downstream accept.
- rpt_data  out  8+TS_W  {monitor index[7:0], detection timestamp[TS_W-1:0]}.
- deadlock  out  1  sticky: any monitor qualified since reset/clear.
- pending_cnt  out  8  number of qualified reports not yet sent.

Behaviour:
- Reset values: rpt_valid=0, rpt_data=0, deadlock=0, pending_cnt=0. Timestamp, persist counters, pending mask and reported mask are all 0. FSM is in IDLE.
- Timestamp: TS_W counter, +1 every cycle. Wraps from all-ones to 0 with no flag.
- Persist counter, one per monitor, saturating at THRESH:
  - block_in[i]=0: counter -> 0.
  - block_in[i]=1: counter increments.
- Qualification:
  - Monitor i qualifies at the edge where block_in[i] has been sampled high for THRESH consecutive edges, and reported[i]=0 and pending[i]=0.
  - At that edge: pending[i]<=1, ts_cap[i]<=current timestamp (pre-increment value), deadlock<=1.
  - Further high cycles do not requalify. A monitor is reported at most once until `clear`.
- Deassertion after qualification does not withdraw the pending report.
- FSM:
  - IDLE: if pending mask is nonzero, select the lowest index j. Load rpt_data={j, ts_cap[j]}, set rpt_valid=1, go to SEND. Report appears 1 cycle after the qualifying edge.
  - SEND: rpt_valid and rpt_data are held stable until rpt_valid&rpt_ready. On handshake: pending[j]<=0, reported[j]<=1, rpt_valid<=0, return to IDLE.
  - Minimum spacing between reports is 2 cycles (no back-to-back valid).
- rpt_ready is ignored while rpt_valid=0. rpt_valid never depends combinationally on rpt_ready.
- Simultaneous qualification of several monitors on one edge: all pending bits are set in the same cycle. They are sent lowest index first.
- Qualification of a monitor on the same edge that the handshake completes for another monitor: both updates are applied. No event is lost.
- pending_cnt = popcount(pending mask), registered.
- clear:
  - Zeroes reported mask, pending mask, persist counters and deadlock.
  - Does not disturb a report in SEND: valid and data are held until handshake, and the handshake then sets no reported bit.
  - A qualification on the same edge as clear is discarded; counting restarts from 0.
- Reset asserted mid-transfer: rpt_valid drops asynchronously. No report is replayed after reset.
- Index field: zero-extended to 8 bits.

Test Plan:
- THRESH=16, rpt_ready=1, block_in[2] high for 16 cycles starting at ts=100:
  - Qualifying edge at ts=115: deadlock=1.
  - One cycle later: rpt_valid=1, rpt_data={8'd2, 32'd115}.
  - Handshake on the following edge: exactly one report.
- block_in[0] high for 15 cycles, low 1, high 15 -> no report, deadlock=0.
- block_in[1] and block_in[3] qualify on the same edge, rpt_ready=0 for 5 cycles:
  - pending_cnt=2.
  - Index 1 is held stable for 5 cycles, then sent; index 3 is sent 2 cycles later.
  - pending_cnt goes 2->1->0.
- block_in[2] stays high for 100 cycles after being reported -> no second report.
- Pulse clear with block_in[2] still high -> deadlock=0, a new report for index 2 after 16 more cycles.
- Timestamp preset near wrap: qualification at ts=32'hFFFF_FFFF, next at 32'h0000_0003 -> both reported with the raw values.
- Assert reset while rpt_valid=1 and rpt_ready=0 -> rpt_valid=0 immediately; all outputs at reset values; no stale report after release.
